sap_core: RTL and testbench
===========================

Name: sap_core

Overview:
- Parametrised, single-clock successor to the team's 4-bit-address accumulator CPU.
- Fetch/execute microsequencer; A, B, IR, MAR and PC registers; internal program/data RAM; carry and zero flags with conditional jumps; immediate load; ready/valid output port that stalls on backpressure.
- No gated clocks, no internal tristate bus.
- Sits under Main as the CPU; the testbench or host loads the program through the load port.

Parameters:
- ADDR_W, 4, address/operand width; RAM depth = 2**ADDR_W words.
- OPC_W, 4, opcode width.
- DATA_W, 8, data/instruction width. Must equal OPC_W+ADDR_W; elaboration error otherwise.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- out_data  out  DATA_W  A register value offered on the output port.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  sink accepts when high together with out_valid.
- halted  out  1  core stopped by HLT.
- pc  out  ADDR_W  program counter (debug).
- acc  out  DATA_W  A register (debug).
- flags  out  2  {C,Z} (debug).

Behaviour:
- Reset: on a clk edge with rst=1, the following clear to 0: PC, A, B, IR, MAR, C, Z, stage counter (T0), halted. out_valid=0 during reset. RAM contents are not cleared.
- Program load: mem[prog_addr] <= prog_data on an edge where prog_we=1 and (rst=1 or halted=1). prog_we is ignored otherwise.
- Instruction word: IR[DATA_W-1:ADDR_W] is the opcode; IR[ADDR_W-1:0] is the operand.
- RAM: asynchronous read, synchronous write.
- Fetch (all instructions):
  - T0: MAR <= PC.
  - T1: IR <= mem[MAR]; PC <= PC+1, modulo 2**ADDR_W (15 wraps to 0).
- Execute steps:
  - NOP (0): none. Total 3 cycles.
  - LDA (1): T2 MAR <= operand; T3 A <= mem[MAR]. Total 4 cycles.
  - ADD (2): T2 MAR <= operand; T3 B <= mem[MAR]; T4 A <= A+B, C = carry out of bit DATA_W, Z = (result==0). Total 5 cycles.
  - SUB (3): same sequence as ADD with result = A + ~B + 1. C = carry out, so C=1 iff A>=B unsigned. Z as for ADD. Total 5 cycles.
  - STA (4): T2 MAR <= operand; T3 mem[MAR] <= A. Total 4 cycles.
  - OUT (5): in T2, out_valid=1 and out_data=A. The core stays in T2 until out_ready=1, then proceeds to the next T0. Minimum 3 cycles.
  - JMP (6): T2 PC <= operand. Total 3 cycles.
  - LDI (7): T2 A <= zero-extended operand. Flags unchanged. Total 3 cycles.
  - JC (8): T2 PC <= operand if C=1, else no change. Total 3 cycles.
  - JZ (9): T2 PC <= operand if Z=1, else no change. Total 3 cycles.
  - HLT (15): T2 halted <= 1. All registers are frozen until rst.
  - Opcodes 10–14: execute as NOP.
- Flags: only ADD/SUB write C and Z. Flags persist across all other instructions.
- out_valid:
  - Combinational: (stage==T2 && opcode==OUT && !halted && !rst).
  - out_data = A at all times. A is stable while stalled.
  - A transfer occurs on an edge with out_valid & out_ready. Exactly one transfer per OUT instruction.
- Stall: while waiting in OUT T2, PC, A, B, MAR, IR, flags and stage are all held.
- Reset mid-instruction: aborts immediately. The next cycle is T0 with PC=0. out_valid drops in the same cycle rst is asserted.
- STA to the address of a later instruction: the modified word is fetched on that later fetch (self-modifying code is legal).
- Stage counter width: 3 bits. Unused encodings return to T0.

Test Plan:
- Add and output: load mem0=0x1E (LDA 14), mem1=0x2F (ADD 15), mem2=0x50 (OUT), mem3=0xF0 (HLT), mem14=28, mem15=14; deassert rst; out_ready=1 -> out_valid=1 with out_data=0x2A in cycle 11 (first post-reset cycle = 0); single transfer; halted=1 from cycle 15 on; pc=4.
- SUB flags and conditional jumps:
  - LDI 5; SUB from a word=7 -> A=0xFE, C=0, Z=0; a following JC 12 is not taken.
  - LDI 7; SUB from a word=7 -> A=0x00, C=1, Z=1; JZ 12 is taken, pc=12.
- Backpressure: OUT with out_ready low for 5 cycles -> out_valid held 6 cycles, out_data stable, pc unchanged; exactly one handshake.
- PC wrap and memory write:
  - NOP at address 15 -> the next fetch is from address 0.
  - LDI 9; STA 13; LDA 13 -> A=0x09, mem13=0x09.
- Reset and load gating:
  - rst asserted during ADD T3 -> next cycle pc=0, A=0, flags=0, no out_valid.
  - prog_we pulsed while running -> mem unchanged.
  - prog_we pulsed after HLT -> mem written.
- Parameter sweep: ADDR_W=6, OPC_W=4, DATA_W=10; run a JMP to 63 then NOP -> wraps to pc=0. ADD 0x3FF+0x001 -> A=0, C=1, Z=1.

Source files
------------

// File: rtl/sap_core_if.sv
// Bus bundle for sap_core: the program-load port and the ready/valid output port.
// master = host/testbench side, slave = core side.
interface sap_core_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prog_we, prog_addr, prog_data, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/sap_core.sv
// sap_core: parametrised accumulator CPU with a fetch/execute microsequencer,
// internal program/data RAM, C/Z flags and a stalling ready/valid output port.
//
// stage | meaning
// ------+------------------------------------------------------------
// T0    | MAR <= PC
// T1    | IR <= mem[MAR], PC <= PC+1
// T2    | first execute step (NOP/JMP/LDI/JC/JZ/HLT finish, OUT waits)
// T3    | LDA/STA finish, ADD/SUB fetch operand into B
// T4    | ADD/SUB write A and flags
module sap_core #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sap_core_if.slave         bus,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [1:0]        flags
);

  // The instruction word is exactly opcode followed by operand.
  if (DATA_W != OPC_W + ADDR_W) begin : g_width_check
    $error("sap_core: DATA_W must equal OPC_W + ADDR_W");
  end

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  typedef enum logic [2:0] {
    S_T0 = 3'd0,
    S_T1 = 3'd1,
    S_T2 = 3'd2,
    S_T3 = 3'd3,
    S_T4 = 3'd4
  } stage_e;

  stage_e            stage_q, stage_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              core_we;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] mem_rdata;
  logic              is_sub;
  logic [DATA_W:0]   alu_sum;

  assign opcode    = ir_q[DATA_W-1:ADDR_W];
  assign operand   = ir_q[ADDR_W-1:0];
  assign mem_rdata = mem_q[mar_q];

  // SUB is A + ~B + 1, so the carry out doubles as "no borrow" (A >= B).
  assign is_sub  = (opcode == OP_SUB);
  assign alu_sum = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + {{DATA_W{1'b0}}, is_sub};

  // Microsequencer: next-state and register updates for the current stage.
  always_comb begin
    stage_d  = stage_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    c_d      = c_q;
    z_d      = z_q;
    halted_d = halted_q;
    core_we  = 1'b0;

    if (!halted_q) begin
      case (stage_q)
        S_T0: begin
          mar_d   = pc_q;
          stage_d = S_T1;
        end
        S_T1: begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          stage_d = S_T2;
        end
        S_T2: begin
          stage_d = S_T0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_d   = operand;
              stage_d = S_T3;
            end
            OP_OUT: begin
              // Hold everything until the sink takes the word.
              if (!bus.out_ready) stage_d = S_T2;
            end
            OP_JMP: pc_d = operand;
            OP_LDI: a_d = {{OPC_W{1'b0}}, operand};
            OP_JC:  if (c_q) pc_d = operand;
            OP_JZ:  if (z_q) pc_d = operand;
            OP_HLT: halted_d = 1'b1;
            default: ;
          endcase
        end
        S_T3: begin
          stage_d = S_T0;
          case (opcode)
            OP_LDA: a_d = mem_rdata;
            OP_ADD, OP_SUB: begin
              b_d     = mem_rdata;
              stage_d = S_T4;
            end
            OP_STA: core_we = 1'b1;
            default: ;
          endcase
        end
        S_T4: begin
          stage_d = S_T0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            a_d = alu_sum[DATA_W-1:0];
            c_d = alu_sum[DATA_W];
            z_d = (alu_sum[DATA_W-1:0] == '0);
          end
        end
        default: stage_d = S_T0;
      endcase
    end
  end

  // Architectural registers with synchronous reset; RAM is not part of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= S_T0;
      pc_q     <= '0;
      mar_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ir_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      c_q      <= c_d;
      z_q      <= z_d;
      halted_q <= halted_d;
    end
  end

  // RAM write port: host loads only while held in reset or halted, else STA.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (rst || halted_q)) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end else if (core_we && !rst) begin
      mem_q[mar_q] <= a_q;
    end
  end

  // Output port and debug taps.
  always_comb begin
    bus.out_data  = a_q;
    bus.out_valid = (stage_q == S_T2) && (opcode == OP_OUT) && !halted_q && !rst;
    halted        = halted_q;
    pc            = pc_q;
    acc           = a_q;
    flags         = {c_q, z_q};
  end

endmodule

// File: tb/tb_sap_core.sv
// Directed and random programs for sap_core, checked against an
// instruction-level model of the ISA (results, flags, outputs, cycle cost).
module tb_sap_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst6;
  logic       halted, halted6;
  logic [3:0] pc;
  logic [7:0] acc;
  logic [1:0] flags, flags6;
  logic [5:0] pc6;
  logic [9:0] acc6;

  sap_core_if #(.ADDR_W(4), .DATA_W(8))  bus ();
  sap_core_if #(.ADDR_W(6), .DATA_W(10)) bus6 ();

  sap_core #(.ADDR_W(4), .OPC_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .pc(pc), .acc(acc), .flags(flags)
  );

  sap_core #(.ADDR_W(6), .OPC_W(4), .DATA_W(10)) dut6 (
    .clk(clk), .rst(rst6), .bus(bus6), .halted(halted6), .pc(pc6), .acc(acc6), .flags(flags6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [16];
  int m_mem [16];
  int m_a, m_c, m_z, m_pc, m_cycles;
  bit m_halt;
  int m_outs [$];
  int dut_outs [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    bus.prog_we = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = prog[i];
      m_mem[i]      = int'(prog[i]);
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  task automatic load6(input logic [5:0] a, input logic [9:0] d);
    bus6.prog_we   = 1'b1;
    bus6.prog_addr = a;
    bus6.prog_data = d;
    tick();
    bus6.prog_we = 1'b0;
  endtask

  // Instruction-level model: executes the program and totals cycle cost.
  task automatic model_run();
    int ir, op, opr, lhs, rhs, res;
    m_a = 0; m_c = 0; m_z = 0; m_pc = 0; m_cycles = 0; m_halt = 0;
    m_outs.delete();
    for (int n = 0; n < 400 && !m_halt; n++) begin
      ir   = m_mem[m_pc];
      op   = ir / 16;
      opr  = ir % 16;
      m_pc = (m_pc + 1) % 16;
      m_cycles += 3;
      case (op)
        1: begin m_a = m_mem[opr]; m_cycles += 1; end
        2, 3: begin
          lhs = m_a;
          rhs = m_mem[opr];
          if (op == 2) begin
            res = lhs + rhs;
            m_c = (res > 255) ? 1 : 0;
          end else begin
            res = lhs - rhs + 256;
            m_c = (lhs >= rhs) ? 1 : 0;
          end
          m_a = res % 256;
          m_z = (m_a == 0) ? 1 : 0;
          m_cycles += 2;
        end
        4: begin m_mem[opr] = m_a; m_cycles += 1; end
        5: m_outs.push_back(m_a);
        6: m_pc = opr;
        7: m_a = opr;
        8: if (m_c == 1) m_pc = opr;
        9: if (m_z == 1) m_pc = opr;
        15: m_halt = 1;
        default: ;
      endcase
    end
  endtask

  task automatic run_to_halt(input int budget, input bit rand_ready, output int cyc, output int stalls);
    dut_outs.delete();
    stalls = 0;
    cyc = 0;
    while (cyc < budget && halted !== 1'b1) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_ready) dut_outs.push_back(int'(bus.out_data));
      if (bus.out_valid === 1'b1 && !bus.out_ready) stalls++;
      tick();
      cyc++;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic compare_run(input string tag, input bit rand_ready);
    int cyc, stalls;
    model_run();
    rst = 1'b0;
    run_to_halt(500, rand_ready, cyc, stalls);
    check({tag, " halted"}, 32'(halted), 32'(1));
    check({tag, " acc"}, 32'(acc), 32'(m_a));
    check({tag, " flags"}, 32'(flags), 32'(m_c * 2 + m_z));
    check({tag, " pc"}, 32'(pc), 32'(m_pc));
    check({tag, " out count"}, 32'(dut_outs.size()), 32'(m_outs.size()));
    for (int i = 0; i < m_outs.size(); i++)
      check($sformatf("%s out%0d", tag, i), (i < dut_outs.size()) ? 32'(dut_outs[i]) : 32'hFFFF_FFFF, 32'(m_outs[i]));
    check({tag, " cycles"}, 32'(cyc), 32'(m_cycles + stalls));
  endtask

  initial begin
    int first_v, first_h, hs, vdata, cyc, stalls, k;

    rst = 1'b1;
    rst6 = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.out_ready = 1'b1;
    bus6.prog_we = 1'b0; bus6.prog_addr = '0; bus6.prog_data = '0; bus6.out_ready = 1'b1;
    hold_reset();

    check("reset pc", 32'(pc), 32'(0));
    check("reset acc", 32'(acc), 32'(0));
    check("reset flags", 32'(flags), 32'(0));
    check("reset halted", 32'(halted), 32'(0));
    check("reset out_valid", 32'(bus.out_valid), 32'(0));

    // Add and output with exact cycle timing.
    prog = '{default: 8'h00};
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h50; prog[3] = 8'hF0;
    prog[14] = 8'd28; prog[15] = 8'd14;
    load_prog();
    rst = 1'b0;
    first_v = -1; first_h = -1; hs = 0; vdata = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid === 1'b1 && first_v < 0) begin first_v = c; vdata = int'(bus.out_data); end
      if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
      if (halted === 1'b1 && first_h < 0) first_h = c;
      tick();
    end
    check("add first valid cycle", 32'(first_v), 32'(11));
    check("add out_data", 32'(vdata), 32'h2A);
    check("add handshakes", 32'(hs), 32'(1));
    check("add halted cycle", 32'(first_h), 32'(15));
    check("add pc", 32'(pc), 32'(4));
    check("add flags", 32'(flags), 32'(0));

    // SUB borrow, JC not taken.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h75; prog[1] = 8'h3F; prog[2] = 8'h8C; prog[3] = 8'h50; prog[4] = 8'hF0;
    prog[12] = 8'h71; prog[13] = 8'h50; prog[14] = 8'hF0; prog[15] = 8'h07;
    load_prog();
    compare_run("subjc", 1'b0);
    check("subjc acc", 32'(acc), 32'hFE);
    check("subjc flags", 32'(flags), 32'(0));
    check("subjc pc", 32'(pc), 32'(5));

    // SUB to zero, JZ taken.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h77; prog[1] = 8'h3F; prog[2] = 8'h9C; prog[3] = 8'hF0;
    prog[12] = 8'hF0; prog[15] = 8'h07;
    load_prog();
    rst = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    check("subjz pc after jz", 32'(pc), 32'(12));
    check("subjz acc", 32'(acc), 32'(0));
    check("subjz flags", 32'(flags), 32'b11);
    run_to_halt(50, 1'b0, cyc, stalls);
    check("subjz halted", 32'(halted), 32'(1));
    check("subjz final pc", 32'(pc), 32'(13));

    // Backpressure: 5 stalled cycles, then accept; reset drops valid at once.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h73; prog[1] = 8'h50; prog[2] = 8'h74; prog[3] = 8'h50; prog[4] = 8'hF0;
    load_prog();
    bus.out_ready = 1'b0;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 20 && bus.out_valid !== 1'b1) begin tick(); cyc++; end
    check("bp valid cycle", 32'(cyc), 32'(5));
    hs = 0;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp stall%0d valid", s), 32'(bus.out_valid), 32'(1));
      check($sformatf("bp stall%0d data", s), 32'(bus.out_data), 32'h03);
      check($sformatf("bp stall%0d pc", s), 32'(pc), 32'(2));
      if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
      tick();
    end
    bus.out_ready = 1'b1;
    check("bp accept valid", 32'(bus.out_valid), 32'(1));
    check("bp accept data", 32'(bus.out_data), 32'h03);
    if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
    tick();
    bus.out_ready = 1'b0;
    check("bp valid after accept", 32'(bus.out_valid), 32'(0));
    check("bp handshakes", 32'(hs), 32'(1));
    cyc = 0;
    while (cyc < 20 && bus.out_valid !== 1'b1) begin tick(); cyc++; end
    check("bp second out data", 32'(bus.out_data), 32'h04);
    rst = 1'b1;
    #1;
    check("bp valid drops on rst", 32'(bus.out_valid), 32'(0));

    // PC wrap from 15 to 0, then LDI/STA/LDA round trip.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h94; prog[1] = 8'h3E; prog[2] = 8'h6F; prog[15] = 8'h00;
    prog[4] = 8'h79; prog[5] = 8'h4D; prog[6] = 8'h70; prog[7] = 8'h1D;
    prog[8] = 8'h50; prog[9] = 8'hF0;
    load_prog();
    rst = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    check("wrap pc", 32'(pc), 32'(0));
    run_to_halt(100, 1'b0, cyc, stalls);
    check("wrap halted", 32'(halted), 32'(1));
    check("sta/lda acc", 32'(acc), 32'h09);
    check("sta/lda out", (dut_outs.size() > 0) ? 32'(dut_outs[0]) : 32'hFFFF_FFFF, 32'h09);
    check("sta/lda pc", 32'(pc), 32'(10));

    // Self-modifying: STA overwrites a later instruction with LDI 12.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h1F; prog[1] = 8'h43; prog[2] = 8'h00; prog[3] = 8'hF0;
    prog[4] = 8'h50; prog[5] = 8'hF0; prog[15] = 8'h7C;
    load_prog();
    compare_run("selfmod", 1'b0);
    check("selfmod out", (dut_outs.size() > 0) ? 32'(dut_outs[0]) : 32'hFFFF_FFFF, 32'h0C);

    // Reset during T3 of an ADD.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h75; prog[1] = 8'h2F; prog[2] = 8'h2F; prog[3] = 8'hF0; prog[15] = 8'hFF;
    load_prog();
    rst = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    check("midrst pre flags", 32'(flags), 32'b10);
    check("midrst pre acc", 32'(acc), 32'h04);
    rst = 1'b1;
    tick();
    check("midrst pc", 32'(pc), 32'(0));
    check("midrst acc", 32'(acc), 32'(0));
    check("midrst flags", 32'(flags), 32'(0));
    check("midrst valid", 32'(bus.out_valid), 32'(0));

    // Load gating: ignored while running, accepted while halted.
    hold_reset();
    prog = '{default: 8'h00};
    prog[0] = 8'h71; prog[5] = 8'h1E; prog[6] = 8'h50; prog[7] = 8'hF0; prog[14] = 8'h33;
    load_prog();
    rst = 1'b0;
    tick(); tick();
    bus.prog_we = 1'b1; bus.prog_addr = 4'd14; bus.prog_data = 8'h55;
    tick();
    bus.prog_we = 1'b0;
    run_to_halt(100, 1'b0, cyc, stalls);
    check("gate running out", (dut_outs.size() > 0) ? 32'(dut_outs[0]) : 32'hFFFF_FFFF, 32'h33);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd14; bus.prog_data = 8'h66;
    tick();
    bus.prog_we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to_halt(100, 1'b0, cyc, stalls);
    check("gate halted out", (dut_outs.size() > 0) ? 32'(dut_outs[0]) : 32'hFFFF_FFFF, 32'h66);

    // Random forward-only programs with random backpressure.
    for (int r = 0; r < 10; r++) begin
      prog = '{default: 8'h00};
      for (int i = 0; i < 10; i++) begin
        k = int'($urandom_range(0, 9));
        case (k)
          0: prog[i] = {4'h7, 4'($urandom_range(0, 15))};
          1: prog[i] = {4'h2, 4'($urandom_range(11, 15))};
          2: prog[i] = {4'h3, 4'($urandom_range(11, 15))};
          3: prog[i] = {4'h1, 4'($urandom_range(10, 15))};
          4: prog[i] = {4'h4, 4'($urandom_range(11, 15))};
          5: prog[i] = 8'h50;
          6: prog[i] = {4'h8, 4'($urandom_range(i + 1, 10))};
          7: prog[i] = {4'h9, 4'($urandom_range(i + 1, 10))};
          8: prog[i] = {4'($urandom_range(10, 14)), 4'($urandom_range(0, 15))};
          default: prog[i] = {4'h6, 4'($urandom_range(i + 1, 10))};
        endcase
      end
      prog[10] = 8'hF0;
      for (int i = 11; i < 16; i++) prog[i] = 8'($urandom);
      hold_reset();
      load_prog();
      compare_run($sformatf("rand%0d", r), 1'b1);
    end

    // Wider instance: PC wrap from 63 and 10-bit carry/zero.
    rst6 = 1'b1;
    tick();
    load6(6'd0, 10'h245);
    load6(6'd1, 10'h07E);
    load6(6'd2, 10'h0BD);
    load6(6'd3, 10'h1BF);
    load6(6'd5, 10'h3C0);
    load6(6'd61, 10'h001);
    load6(6'd62, 10'h3FF);
    load6(6'd63, 10'h000);
    rst6 = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    check("w6 wrap pc", 32'(pc6), 32'(0));
    check("w6 acc after add", 32'(acc6), 32'(0));
    check("w6 flags", 32'(flags6), 32'b11);
    cyc = 0;
    while (cyc < 60 && halted6 !== 1'b1) begin tick(); cyc++; end
    check("w6 halted", 32'(halted6), 32'(1));
    check("w6 final pc", 32'(pc6), 32'(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
